// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings and configuration checks for the parametrised UART receiver
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_e;
  function automatic bit cfg_ok(int cpb, int db, int par, int sb);
    return cpb >= 8 && db >= 5 && db <= 9 && par >= PAR_NONE && par <= PAR_EVEN && (sb == 1 || sb == 2);
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: line synchroniser, per-bit counter and 3-sample majority vote
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  input  logic en_i,
  output logic rx_s_o,
  output logic bit_val_o,
  output logic bit_done_o,
  output logic mid_done_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int MID = (CLKS_PER_BIT - 1) / 2;
  logic [1:0] sync_q;
  logic [1:0] smp_q, smp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign rx_s_o = sync_q[1];
  assign bit_done_o = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign mid_done_o = cnt_q == CW'(MID + 1);
  // third vote is the live sample, so the result is valid exactly when mid_done_o is high
  assign bit_val_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_o) | (smp_q[1] & rx_s_o);
  always_comb begin
    cnt_d = (!en_i || bit_done_o) ? '0 : cnt_q + CW'(1);
    smp_d = cnt_q == CW'(MID - 1) ? {smp_q[1], rx_s_o} :
            cnt_q == CW'(MID)     ? {rx_s_o, smp_q[0]} : smp_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      sync_q <= '1;
      cnt_q  <= '0;
      smp_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      cnt_q  <= cnt_d;
      smp_q  <= smp_d;
    end
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: configurable UART receiver with parity, framing and break detection
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);
  if (!cfg_ok(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS)) begin : g_cfg_err
    $error("uart_rx_param: illegal configuration");
  end
  state_e state_q;
  logic [DATA_BITS-1:0] shreg_q, byte_q;
  logic [3:0] idx_q;
  logic stop_q, par_q, nz_q, fe_q, pe_q;
  logic dv_q, perr_q, ferr_q, brk_q;
  logic rx_s, bit_val, bit_done, mid_done, en, last_stop, frame_fe;
  uart_rx_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clk_i(i_Clock), .rst_i(i_Reset), .rx_i(i_Rx_Serial), .en_i(en),
    .rx_s_o(rx_s), .bit_val_o(bit_val), .bit_done_o(bit_done), .mid_done_o(mid_done)
  );
  // frame closes mid-way through the last stop bit so the next start edge is never missed
  assign last_stop = state_q == S_STOP && mid_done && (STOP_BITS == 1 || stop_q);
  assign frame_fe = fe_q | !bit_val;
  assign en = state_q == S_IDLE      ? !rx_s :
              state_q == S_START     ? !(mid_done && bit_val) :
              state_q == S_WAIT_IDLE ? 1'b0 : !last_stop;
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      byte_q  <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      nz_q    <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      dv_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      brk_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (!rx_s) begin
          state_q <= S_START;
          idx_q   <= '0;
          stop_q  <= 1'b0;
          par_q   <= 1'b0;
          nz_q    <= 1'b0;
          fe_q    <= 1'b0;
          pe_q    <= 1'b0;
        end
        S_START:
          if (mid_done && bit_val) state_q <= S_IDLE;
          else if (bit_done) state_q <= S_DATA;
        S_DATA: begin
          if (mid_done) begin
            shreg_q <= {bit_val, shreg_q[DATA_BITS-1:1]};
            par_q   <= par_q ^ bit_val;
            nz_q    <= nz_q | bit_val;
          end
          if (bit_done) begin
            idx_q <= idx_q + 4'd1;
            if (idx_q == 4'(DATA_BITS - 1)) state_q <= PARITY != PAR_NONE ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (mid_done) begin
            pe_q <= (par_q ^ bit_val) != (PARITY == PAR_ODD);
            nz_q <= nz_q | bit_val;
          end
          if (bit_done) state_q <= S_STOP;
        end
        S_STOP:
          if (last_stop) begin
            dv_q    <= 1'b1;
            byte_q  <= shreg_q;
            perr_q  <= pe_q;
            ferr_q  <= frame_fe;
            brk_q   <= !nz_q && !bit_val;
            state_q <= frame_fe ? S_WAIT_IDLE : S_IDLE;
          end else begin
            if (mid_done && !bit_val) fe_q <= 1'b1;
            if (bit_done) stop_q <= 1'b1;
          end
        S_WAIT_IDLE: if (rx_s) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  assign o_Rx_DV = dv_q;
  assign o_Rx_Byte = byte_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err = ferr_q;
  assign o_Break = brk_q;
  assign o_Busy = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench over three receiver configurations
module tb_uart_rx_param;
  localparam int CPB = 16;
  localparam int MID = (CPB - 1) / 2;
  localparam int LAT = 2 + 9 * CPB + MID + 2;
  localparam int LAT_C = 2 + 10 * CPB + MID + 2;
  typedef struct {
    logic [8:0] data;
    logic pe, fe, brk;
    int cyc;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic dv_a, pe_a, fe_a, brk_a, busy_a;
  logic dv_b, pe_b, fe_b, brk_b, busy_b;
  logic dv_c, pe_c, fe_c, brk_c, busy_c;
  logic [7:0] byte_a, byte_c;
  logic [6:0] byte_b;
  int cyc = 0, n_chk = 0, n_pass = 0;
  exp_t qa[$], qb[$], qc[$];
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a), .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a),
    .o_Parity_Err(pe_a), .o_Frame_Err(fe_a), .o_Break(brk_a), .o_Busy(busy_a));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b), .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b),
    .o_Parity_Err(pe_b), .o_Frame_Err(fe_b), .o_Break(brk_b), .o_Busy(busy_b));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_c), .o_Rx_DV(dv_c), .o_Rx_Byte(byte_c),
    .o_Parity_Err(pe_c), .o_Frame_Err(fe_c), .o_Break(brk_c), .o_Busy(busy_c));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction
  function automatic void cmp(string tag, exp_t e, logic [8:0] d, logic pe, logic fe, logic brk);
    chk({tag, " data"}, 32'(d), 32'(e.data));
    chk({tag, " perr"}, 32'(pe), 32'(e.pe));
    chk({tag, " ferr"}, 32'(fe), 32'(e.fe));
    chk({tag, " break"}, 32'(brk), 32'(e.brk));
    chk({tag, " dv cycle"}, cyc, e.cyc);
  endfunction
  function automatic exp_t mk(logic [8:0] d, logic pe, logic fe, logic brk, int c);
    mk.data = d; mk.pe = pe; mk.fe = fe; mk.brk = brk; mk.cyc = c;
  endfunction
  always @(negedge clk) if (dv_a) begin
    if (qa.size() == 0) chk("A unexpected dv", 1, 0);
    else cmp("A", qa.pop_front(), {1'b0, byte_a}, pe_a, fe_a, brk_a);
  end
  always @(negedge clk) if (dv_b) begin
    if (qb.size() == 0) chk("B unexpected dv", 1, 0);
    else cmp("B", qb.pop_front(), {2'b0, byte_b}, pe_b, fe_b, brk_b);
  end
  always @(negedge clk) if (dv_c) begin
    if (qc.size() == 0) chk("C unexpected dv", 1, 0);
    else cmp("C", qc.pop_front(), {1'b0, byte_c}, pe_c, fe_c, brk_c);
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else if (sel == 1) rx_b = v;
    else rx_c = v;
  endtask
  task automatic send(input int sel, input logic [8:0] d, input int db, input int par,
                      input logic flip, input int nstop, input logic last_stop, input int glitch);
    logic [12:0] bits;
    logic px;
    int n;
    bits = '0;
    px = 1'b0;
    for (int i = 0; i < db; i++) begin
      bits[1+i] = d[i];
      px ^= d[i];
    end
    n = 1 + db;
    if (par != 0) begin
      bits[n] = px ^ (par == 1) ^ flip;
      n++;
    end
    for (int s = 0; s < nstop; s++) begin
      bits[n] = (s == nstop - 1) ? last_stop : 1'b1;
      n++;
    end
    for (int i = 0; i < n; i++) begin
      drive(sel, bits[i]);
      if (i == glitch) begin
        tick(MID);
        drive(sel, !bits[i]);
        tick(1);
        drive(sel, bits[i]);
        tick(CPB - MID - 1);
      end else tick(CPB);
    end
  endtask
  initial begin
    #1;
    chk("A reset outputs", {dv_a, byte_a, pe_a, fe_a, brk_a, busy_a}, 0);
    chk("B reset outputs", {dv_b, byte_b, pe_b, fe_b, brk_b, busy_b}, 0);
    chk("C reset outputs", {dv_c, byte_c, pe_c, fe_c, brk_c, busy_c}, 0);
    tick(3);
    rst = 1'b0;
    tick(3);
    qa.push_back(mk(9'hA5, 0, 0, 0, cyc + LAT));
    send(0, 9'hA5, 8, 0, 0, 1, 1, -1);
    qa.push_back(mk(9'h5A, 0, 0, 0, cyc + LAT));
    send(0, 9'h5A, 8, 0, 0, 1, 1, 4);
    tick(10);
    qb.push_back(mk(9'h55, 0, 0, 0, cyc + LAT));
    send(1, 9'h55, 7, 2, 0, 1, 1, -1);
    qb.push_back(mk(9'h55, 1, 0, 0, cyc + LAT));
    send(1, 9'h55, 7, 2, 1, 1, 1, -1);
    tick(10);
    drive(0, 0);
    tick(1);
    drive(0, 1);
    tick(3);
    chk("glitch busy rises", busy_a, 1);
    tick(7);
    chk("glitch busy clears", busy_a, 0);
    drive(0, 0);
    tick(3);
    drive(0, 1);
    tick(MID + 4);
    chk("pulse busy clears", busy_a, 0);
    tick(20);
    qc.push_back(mk(9'hA5, 0, 1, 0, cyc + LAT_C));
    send(2, 9'hA5, 8, 0, 0, 2, 0, -1);
    tick(5 * CPB);
    chk("C waits while low", busy_c, 1);
    drive(2, 1);
    tick(4);
    chk("C rearms", busy_c, 0);
    qc.push_back(mk(9'h3C, 0, 0, 0, cyc + LAT_C));
    send(2, 9'h3C, 8, 0, 0, 2, 1, -1);
    tick(10);
    qa.push_back(mk(9'h00, 0, 1, 1, cyc + LAT));
    drive(0, 0);
    tick(12 * CPB);
    chk("break waits while low", busy_a, 1);
    drive(0, 1);
    tick(4);
    chk("break rearms", busy_a, 0);
    qa.push_back(mk(9'h01, 0, 0, 0, cyc + LAT));
    qa.push_back(mk(9'hFF, 0, 0, 0, cyc + 10 * CPB + LAT));
    qa.push_back(mk(9'h80, 0, 0, 0, cyc + 20 * CPB + LAT));
    send(0, 9'h01, 8, 0, 0, 1, 1, -1);
    send(0, 9'hFF, 8, 0, 0, 1, 1, -1);
    send(0, 9'h80, 8, 0, 0, 1, 1, -1);
    tick(5);
    drive(0, 0);
    tick(CPB);
    drive(0, 1);
    tick(CPB);
    drive(0, 0);
    tick(2 * CPB);
    drive(0, 1);
    rst = 1'b1;
    #1;
    chk("abort reset outputs", {dv_a, byte_a, pe_a, fe_a, brk_a, busy_a}, 0);
    tick(2);
    rst = 1'b0;
    tick(12 * CPB);
    chk("A queue drained", qa.size(), 0);
    chk("B queue drained", qb.size(), 0);
    chk("C queue drained", qc.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 test receiver.
- Configurable data width, parity mode and stop-bit count.
- 3-sample majority vote per bit; false-start rejection.
- Parity, framing and break detection; re-arms only after the line returns idle.
- Sits behind the UART pad in the bus protocol block and feeds received words plus status to the UART register/FIFO front end.

Parameters:
- CLKS_PER_BIT, 87, clocks per bit period; legal range >= 8.
- DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
- i_Clock  input  1  system clock
- i_Reset  input  1  asynchronous, active-high reset
- i_Rx_Serial  input  1  asynchronous serial line; idles high
- o_Rx_DV  output  1  one-cycle pulse: frame complete
- o_Rx_Byte  output  DATA_BITS  received word; held until the next o_Rx_DV
- o_Parity_Err  output  1  parity mismatch; valid only with o_Rx_DV
- o_Frame_Err  output  1  a stop bit sampled 0; valid only with o_Rx_DV
- o_Break  output  1  all data bits 0, parity bit (if any) 0, stop bit 0; valid only with o_Rx_DV
- o_Busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, i_Clock; reset is asynchronous and active-high on i_Reset.
- Reset values: both synchroniser flops 1; all outputs 0; counters 0; state IDLE.
- Reset asserted mid-frame aborts the frame with no o_Rx_DV.
- Synchroniser: 2-flop synchroniser on i_Rx_Serial; all logic uses the synchronised bit, rx_s.
- Timing constants: MID = (CLKS_PER_BIT-1)/2 (integer division); counter width = $clog2(CLKS_PER_BIT).
- Per-bit counter: runs 0..CLKS_PER_BIT-1, then wraps to 0 and advances to the next bit.
- Sampling: in each bit, rx_s is sampled at counts MID-1, MID and MID+1; the bit value is the majority of the three samples.
- State: IDLE
  - Enter START on rx_s == 0, counter = 0.
- State: START
  - At count MID+1, if the majority is 1, it is a false start: return to IDLE with no flags.
  - Otherwise continue to count CLKS_PER_BIT-1, then go to DATA.
- State: DATA
  - Bit index 0..DATA_BITS-1; shift register filled LSB first.
  - After the last bit, go to PARITY if PARITY != 0, else to STOP.
- State: PARITY
  - Error if XOR(data, parity bit) != 1 for odd, or != 0 for even.
- State: STOP
  - Each stop bit whose majority is 0 sets the frame-error flag.
  - Early resync: the frame ends at count MID+1 of the last stop bit, not at the end of the bit.
  - At that point, on the next edge: o_Rx_DV = 1, o_Rx_Byte loaded, error/break flags driven.
  - Next state is IDLE if the frame is error-free, else WAIT_IDLE.
- State: WAIT_IDLE
  - Entered on frame error (including break).
  - Stays until rx_s == 1 for one cycle, then goes to IDLE. No new start is accepted while the line stays low.
- Pulse width: o_Rx_DV, o_Parity_Err, o_Frame_Err and o_Break are high exactly one cycle; zero otherwise.
- Back-to-back frames: the next start bit may be detected in the first IDLE cycle after o_Rx_DV, so frames with zero idle gap are received without loss.
- Latency: let cycle 0 be the first cycle rx_s == 0, and N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.
  - o_Rx_DV is high in cycle (N-1)*CLKS_PER_BIT + MID + 2.
  - Add 2 cycles of synchroniser delay relative to i_Rx_Serial.
- Tolerance: with the 3-sample vote, a single-cycle glitch inside any bit does not corrupt the data.

Decomposition:
- Package uart_pkg:
  - Parity encodings: PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
  - 3-bit state encoding: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - Elaboration-time parameter range checks.
- Sub-module uart_rx_sampler: synchroniser, bit counter, 3-sample majority vote.
  - Outputs rx_s, bit_val, bit_done (count == CLKS_PER_BIT-1) and mid_done (count == MID+1).
- The top level holds the FSM, shift register and flag logic.

Test Plan:
1. Default configuration (CLKS_PER_BIT=16, 8N1); send 0xA5 -> one o_Rx_DV pulse, o_Rx_Byte = 0xA5, all flags 0, DV exactly at the latency formula +2 cycles.
2. PARITY=2, DATA_BITS=7; send 0x55 with correct parity, then 0x55 with flipped parity -> first frame o_Parity_Err = 0; second o_Parity_Err = 1 and o_Rx_Byte = 0x55.
3. 1-cycle low glitch on an idle line, then a 3-cycle low pulse -> no o_Rx_DV for either; o_Busy returns to 0 within MID+2 cycles.
4. STOP_BITS=2; second stop bit driven 0 -> o_Frame_Err = 1; with the line then held low for 5 bit times, no further o_Rx_DV until the line goes high.
5. Line held low for 12 bit periods (8N1) -> o_Rx_DV with o_Break = 1, o_Frame_Err = 1, o_Rx_Byte = 0x00; state WAIT_IDLE until the line rises.
6. Frames 0x01, 0xFF, 0x80 sent with zero idle gap -> three DV pulses in order; i_Reset asserted mid-frame during a fourth frame -> outputs 0 immediately and no DV for the aborted frame.
